// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types for the pipelined MIPS inter-stage registers
package pipe_pkg;

    // Occupancy of one pipeline stage register
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

    // IF/ID: fetched instruction and its fall-through PC
    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } if_id_t;

    // ID/EX: decoded controls, register operands and immediate
    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        alu_src;
        logic        reg_dst;
        logic [3:0]  alu_ctrl;
        logic [31:0] pc_plus4;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } id_ex_t;

    // EX/MEM: ALU result, store data and destination
    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_read;
        logic        mem_write;
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [4:0]  dest;
    } ex_mem_t;

    // MEM/WB: write-back value selection inputs
    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] mem_data;
        logic [31:0] alu_result;
        logic [4:0]  dest;
    } mem_wb_t;

    localparam int IF_ID_W  = $bits(if_id_t);
    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline stage register with optional 2-entry skid
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit SKID       = 1'b1,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    stage_state_t     state;
    stage_state_t     state_nxt;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_nxt;
    logic [WIDTH-1:0] skid_q;
    logic             main_load;
    logic             skid_load;
    logic             push;
    logic             pop;

    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = (state == TWO) ? 2'd2 : ((state == ONE) ? 2'd1 : 2'd0);

    // With the skid entry, ready depends only on the state flop; without it, a
    // full register can still accept when downstream drains it this cycle.
    if (SKID) begin : g_ready_skid
        assign in_ready = (state != TWO) & ~RST;
    end else begin : g_ready_pass
        assign in_ready = (~out_valid | out_ready) & ~RST;
    end

    // Next-state and register-load decode for the handshake
    always_comb begin
        state_nxt = state;
        main_load = 1'b0;
        main_nxt  = in_data;
        skid_load = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt = ONE;
                    main_load = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    main_load = 1'b1;
                end else if (push && SKID) begin
                    state_nxt = TWO;
                    skid_load = 1'b1;
                end else if (pop && !push) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_nxt = ONE;
                    main_load = 1'b1;
                    main_nxt  = skid_q;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // State register: reset beats flush, flush beats the handshake
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Main register: zeroing turns a dropped stage into a NOP bubble
    if (CLEAR_DATA) begin : g_main_clear
        always_ff @(posedge CLK) begin
            if (RST || flush) begin
                main_q <= '0;
            end else if (main_load) begin
                main_q <= main_nxt;
            end
        end
    end else begin : g_main_keep
        always_ff @(posedge CLK) begin
            if (!RST && !flush && main_load) begin
                main_q <= main_nxt;
            end
        end
    end

    // Skid register: holds the beat accepted while downstream stalled
    if (SKID) begin : g_skid
        if (CLEAR_DATA) begin : g_skid_clear
            always_ff @(posedge CLK) begin
                if (RST || flush) begin
                    skid_q <= '0;
                end else if (skid_load) begin
                    skid_q <= in_data;
                end
            end
        end else begin : g_skid_keep
            always_ff @(posedge CLK) begin
                if (!RST && !flush && skid_load) begin
                    skid_q <= in_data;
                end
            end
        end
    end else begin : g_no_skid
        logic unused_skid_load;
        assign skid_q           = '0;
        assign unused_skid_load = skid_load;
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid in skid and single-register modes
module tb_pipe_stage_skid;

    logic        CLK = 1'b0;
    logic        RST;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        s_ir, s_ov;
    logic [31:0] s_od;
    logic [1:0]  s_cnt;
    logic        r_ir, r_ov;
    logic [31:0] r_od;
    logic [1:0]  r_cnt;

    int checks   = 0;
    int failures = 0;

    // index 1 = skid instance, index 0 = single-register instance
    int          msz [2] = '{0, 0};
    logic [31:0] mbeat [2][2];
    logic [31:0] s_log [$];
    logic [31:0] r_log [$];
    logic        m_push, m_pop;

    always #5 CLK = ~CLK;

    pipe_stage_skid #(.WIDTH(32), .SKID(1'b1), .CLEAR_DATA(1'b1)) u_skid (
        .CLK(CLK), .RST(RST), .flush(flush),
        .in_valid(in_valid), .in_ready(s_ir), .in_data(in_data),
        .out_valid(s_ov), .out_ready(out_ready), .out_data(s_od), .count(s_cnt)
    );

    pipe_stage_skid #(.WIDTH(32), .SKID(1'b0), .CLEAR_DATA(1'b1)) u_reg (
        .CLK(CLK), .RST(RST), .flush(flush),
        .in_valid(in_valid), .in_ready(r_ir), .in_data(in_data),
        .out_valid(r_ov), .out_ready(out_ready), .out_data(r_od), .count(r_cnt)
    );

    function automatic logic exp_ready(input int k);
        if (RST) return 1'b0;
        if (k == 1) return msz[1] < 2;
        return (msz[0] == 0) || out_ready;
    endfunction

    // Reference model: each stage is an ordered list of at most 2 (or 1) beats
    always @(posedge CLK) begin
        if (s_ov === 1'b1 && out_ready === 1'b1) s_log.push_back(s_od);
        if (r_ov === 1'b1 && out_ready === 1'b1) r_log.push_back(r_od);
        for (int k = 0; k < 2; k++) begin
            m_push = in_valid && exp_ready(k);
            m_pop  = (msz[k] > 0) && out_ready;
            if (RST) begin
                msz[k] = 0;
            end else begin
                if (m_pop) begin
                    mbeat[k][0] = mbeat[k][1];
                    msz[k]      = msz[k] - 1;
                end
                if (flush) begin
                    msz[k] = 0;
                end else if (m_push) begin
                    mbeat[k][msz[k]] = in_data;
                    msz[k]           = msz[k] + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("s_in_ready", {31'd0, s_ir}, {31'd0, exp_ready(1)});
        chk("s_out_valid", {31'd0, s_ov}, {31'd0, msz[1] > 0});
        chk("s_count", {30'd0, s_cnt}, msz[1]);
        if (msz[1] > 0) chk("s_out_data", s_od, mbeat[1][0]);
        chk("r_in_ready", {31'd0, r_ir}, {31'd0, exp_ready(0)});
        chk("r_out_valid", {31'd0, r_ov}, {31'd0, msz[0] > 0});
        chk("r_count", {30'd0, r_cnt}, msz[0]);
        if (msz[0] > 0) chk("r_out_data", r_od, mbeat[0][0]);
    endtask

    task automatic tick();
        @(negedge CLK);
        compare_all();
        @(posedge CLK);
        #1;
    endtask

    logic [31:0] s_exp [$];
    logic [31:0] r_exp [$];

    initial begin
        RST = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
        tick(); tick();
        chk("rst_s_out_valid", {31'd0, s_ov}, 32'd0);
        chk("rst_s_in_ready", {31'd0, s_ir}, 32'd0);
        chk("rst_s_count", {30'd0, s_cnt}, 32'd0);
        chk("rst_s_out_data", s_od, 32'd0);
        chk("rst_r_out_data", r_od, 32'd0);
        RST = 1'b0; in_valid = 1'b0;
        #1;
        chk("post_rst_s_in_ready", {31'd0, s_ir}, 32'd1);
        tick();

        // Streaming 1..8 with downstream always ready
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = i;
            tick();
            chk("stream_s_count", {30'd0, s_cnt}, 32'd1);
            chk("stream_s_out_data", s_od, i);
        end
        in_valid = 1'b0;
        tick(); tick();
        chk("stream_s_log_len", s_log.size(), 32'd8);

        // Backpressure: A then B with downstream stalled
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA; tick();
        in_data = 32'hB; tick();
        in_valid = 1'b0;
        #1;
        chk("bp_s_count", {30'd0, s_cnt}, 32'd2);
        chk("bp_s_in_ready", {31'd0, s_ir}, 32'd0);
        chk("bp_s_out_data", s_od, 32'hA);
        chk("bp_r_in_ready", {31'd0, r_ir}, 32'd0);
        tick();
        chk("bp_s_hold_data", s_od, 32'hA);
        chk("bp_r_hold_data", r_od, 32'hA);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hD;
        #1;
        chk("pass_r_in_ready", {31'd0, r_ir}, 32'd1);
        chk("pass_s_in_ready", {31'd0, s_ir}, 32'd0);
        tick();
        in_valid = 1'b0;
        chk("pass_r_out_data", r_od, 32'hD);
        chk("pass_r_count", {30'd0, r_cnt}, 32'd1);
        chk("drain_s_out_data", s_od, 32'hB);
        tick();
        chk("drain_s_out_valid", {31'd0, s_ov}, 32'd0);
        chk("drain_r_out_valid", {31'd0, r_ov}, 32'd0);

        // Flush from TWO with a beat offered
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h1111_0001; tick();
        in_data = 32'h1111_0002; tick();
        flush = 1'b1; in_data = 32'hC;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_s_out_valid", {31'd0, s_ov}, 32'd0);
        chk("flush_s_count", {30'd0, s_cnt}, 32'd0);
        chk("flush_s_out_data", s_od, 32'd0);
        chk("flush_r_out_data", r_od, 32'd0);
        out_ready = 1'b1;
        tick(); tick();

        // Flush in ONE with a simultaneous pop: E leaves, C is dropped
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hE; tick();
        out_ready = 1'b1; flush = 1'b1; in_data = 32'hC;
        #1;
        chk("flush_one_s_in_ready", {31'd0, s_ir}, 32'd1);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_pop_s_out_valid", {31'd0, s_ov}, 32'd0);
        tick(); tick();

        // Reset while TWO holds A and B
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA; tick();
        in_data = 32'hB; tick();
        in_valid = 1'b0; RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("midrst_s_out_valid", {31'd0, s_ov}, 32'd0);
        chk("midrst_s_count", {30'd0, s_cnt}, 32'd0);
        out_ready = 1'b1;
        tick(); tick();
        in_valid = 1'b1; in_data = 32'hC; tick();
        in_valid = 1'b0;
        chk("midrst_c_valid", {31'd0, s_ov}, 32'd1);
        chk("midrst_c_data", s_od, 32'hC);
        tick();
        chk("midrst_c_gone", {31'd0, s_ov}, 32'd0);
        tick();

        // Complete delivered sequences, in order, nothing extra
        for (int i = 1; i <= 8; i++) begin
            s_exp.push_back(i);
            r_exp.push_back(i);
        end
        s_exp.push_back(32'hA); s_exp.push_back(32'hB); s_exp.push_back(32'hE); s_exp.push_back(32'hC);
        r_exp.push_back(32'hA); r_exp.push_back(32'hD); r_exp.push_back(32'hE); r_exp.push_back(32'hC);
        chk("s_log_len", s_log.size(), s_exp.size());
        chk("r_log_len", r_log.size(), r_exp.size());
        for (int i = 0; i < s_exp.size(); i++) begin
            chk("s_log_beat", (i < s_log.size()) ? s_log[i] : 32'hxxxx_xxxx, s_exp[i]);
            chk("r_log_beat", (i < r_log.size()) ? r_log[i] : 32'hxxxx_xxxx, r_exp[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised inter-stage pipeline register for the pipelined MIPS datapath (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a WIDTH-bit packed payload between stages under a valid/ready handshake, with optional 2-entry skid buffering that removes the combinational ready path, plus a flush. It replaces the per-stage hand-written latch-and-enable registers; each stage packs its control and data fields into one payload vector.

## Interface
- WIDTH, 32: payload width in bits, at least 1.
- SKID, 1: 1 selects a 2-entry skid buffer with in_ready driven from flops only; 0 selects a single register with a combinational ready pass-through.
- CLEAR_DATA, 1: 1 zeroes the payload registers on reset and on flush (a zero payload is a NOP bubble); 0 clears only the valid state.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous and active-high.
- flush  in  1  drops all held entries and the beat offered this cycle.
- in_valid  in  1  upstream offers a beat.
- in_ready  out  1  this stage accepts the beat.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  the stage holds a beat for downstream.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  WIDTH  payload of the oldest held beat.
- count  out  2  occupancy, from 0 to 2 (at most 1 when SKID=0).

## Operation
- push = in_valid & in_ready; pop = out_valid & out_ready.
- Storage:
  - main register: drives out_data.
  - skid register: exists only when SKID=1.
- States are EMPTY, ONE and TWO; TWO exists only when SKID=1. out_valid = (state != EMPTY).
- Transitions when RST=0 and flush=0:
  - EMPTY: push → ONE, main ← in_data.
  - ONE, push & pop → ONE, main ← in_data.
  - ONE, push & !pop, SKID=1 → TWO, skid ← in_data.
  - ONE, pop & !push → EMPTY.
  - TWO: pop → ONE, main ← skid. No push is possible in TWO.
  - Any other combination → hold state and data.
- in_ready:
  - SKID=1: in_ready = (state != TWO) & !RST.
  - SKID=0: in_ready = (!out_valid | out_ready) & !RST.
- Flush:
  - Priority: RST > flush > handshake.
  - Next state is EMPTY.
  - A beat offered in the flush cycle counts as consumed if in_ready=1, but it is discarded.
  - A simultaneous pop still completes downstream; the beat leaves, and flush removes whatever remains.
  - CLEAR_DATA=1: main and skid ← 0. CLEAR_DATA=0: data registers hold their old values.
- Reset:
  - State EMPTY, out_valid=0, in_ready=0 while RST=1, count=0, out_data=0 (when CLEAR_DATA=1).
  - Reset mid-transfer discards everything held; no beat is emitted after reset until a new push.
- Order: beats leave in the order they were pushed. No beat is duplicated or lost except by flush or reset.
- count = 0 / 1 / 2 for EMPTY / ONE / TWO.

## Timing
- Latency: a push in cycle N gives out_valid=1 with that payload in cycle N+1. There is no zero-cycle bypass.
- SKID=1: throughput is 1 beat per cycle with out_ready held high. in_ready has no combinational dependence on out_ready or in_valid.
- SKID=0: throughput is 1 beat per cycle. in_ready depends combinationally on out_ready.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid hold, except under flush or RST.
- Flush takes effect on the edge: out_valid=0 in the cycle after flush is asserted. in_ready is unaffected in the flush cycle itself.
- Boundaries:
  - Full (TWO): in_ready=0.
  - Push and pop in the same cycle in ONE keeps occupancy at 1.
  - Empty with out_ready=1 and no push: no pop.

## Structure
- Shared package pipe_pkg:
  - typedef enum logic [1:0] stage_state_t {EMPTY, ONE, TWO}.
  - Per-stage packed payload struct typedefs, whose widths drive WIDTH at instantiation.
- No sub-module; the main register, skid register and state register are inline. SKID and CLEAR_DATA are selected with generate-if.

## Test plan
- Reset: RST=1 for 2 cycles with in_valid=1 and in_data=32'hDEADBEEF → out_valid=0, in_ready=0, count=0, out_data=0. After release, in_ready=1 (SKID=1).
- Streaming: SKID=1, out_ready=1, push 32'h1..32'h8 on consecutive cycles → outputs 1..8 in order starting one cycle later, count stays 1, no bubbles.
- Backpressure: SKID=1, push A=32'hA then B=32'hB with out_ready=0 → count=2, in_ready=0, out_data=A stable. Raise out_ready → A, then B, then EMPTY.
- Flush: state TWO, flush=1 with in_valid=1 and in_data=32'hC → next cycle out_valid=0, count=0, out_data=0 (CLEAR_DATA=1). 32'hC never appears at the output.
- Single-register mode: SKID=0, out_valid=1, out_ready=0 → in_ready=0. Toggle out_ready=1 in the same cycle → in_ready=1 in the same cycle, and push plus pop both occur.
- Reset mid-operation: SKID=1 in TWO holding A and B, RST pulsed for 1 cycle → EMPTY. A and B never appear. The next push C emerges alone one cycle after it is pushed.
